cpu_step_controller: RTL and testbench

Run/step/halt sequencer for the 16-bit CPU datapath. It runs on the 100 MHz board clock and issues single-cycle clock-enable pulses to the datapath in one of two ways: free-running at a divided rate, or one at a time from a debounced step button. It also generates a clean program-restart pulse and halts on a PC breakpoint. It replaces the bare slow-clock arrangement, so the datapath can run from the board clock gated by Cpu_Ce.

---
 rtl/cpu_step_controller_if.sv | 27 ++
 rtl/cpu_step_controller.sv | 223 ++++++++++++++++++++++
 tb/tb_cpu_step_controller.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_step_controller_if.sv
// Bus between the board-side controls and cpu_step_controller.
// master: drives the buttons, switch, PC and breakpoint; reads the enables.
// slave:  the step controller itself.
interface cpu_step_controller_if #(
  parameter int PC_W = 16
);
  logic            Run_Sw;
  logic            Step_Btn;
  logic            Restart_Btn;
  logic [PC_W-1:0] PC_In;
  logic [PC_W-1:0] Brk_Addr;
  logic            Brk_En;
  logic            Cpu_Ce;
  logic            Cpu_Restart;
  logic [1:0]      State;
  logic [15:0]     Cycle_Count;

  modport master (
    output Run_Sw, Step_Btn, Restart_Btn, PC_In, Brk_Addr, Brk_En,
    input  Cpu_Ce, Cpu_Restart, State, Cycle_Count
  );

  modport slave (
    input  Run_Sw, Step_Btn, Restart_Btn, PC_In, Brk_Addr, Brk_En,
    output Cpu_Ce, Cpu_Restart, State, Cycle_Count
  );
endinterface

// File: rtl/cpu_step_controller.sv
// Run/step/halt sequencer for the 16-bit CPU datapath.
// Issues one-cycle Cpu_Ce pulses, either free-running every TICK_DIV board
// cycles (RUN) or one per debounced step press (STEP), plus a one-cycle
// Cpu_Restart pulse on a debounced restart press.
// Optional macro STEP_CTRL_BRK_EN: when defined, RUN halts before executing
// the instruction at Brk_Addr; when undefined, no breakpoint logic is built.
module cpu_step_controller #(
  parameter int TICK_DIV        = 50000000,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int PC_W            = 16
) (
  input  logic                 Clk_100MHz,
  input  logic                 Reset,
  cpu_step_controller_if.slave bus
);

  typedef enum logic [1:0] {
    ST_HALT    = 2'b00,
    ST_RUN     = 2'b01,
    ST_STEP    = 2'b10,
    ST_RESTART = 2'b11
  } state_e;

  // Input channel order inside the synchronizer/debouncer vectors.
  localparam int IDX_RUN     = 0;
  localparam int IDX_STEP    = 1;
  localparam int IDX_RESTART = 2;
  localparam int NUM_IN      = 3;

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam int PS_W = $clog2(TICK_DIV);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);

  // ------------------------------------------------------------------
  // Synchronizers and debouncers
  // ------------------------------------------------------------------
  logic [NUM_IN-1:0] raw_in;
  logic [NUM_IN-1:0] sync1_q, sync2_q;
  logic [NUM_IN-1:0] db_q, db_d;
  logic [CNT_W-1:0]  db_cnt_q [NUM_IN];
  logic [CNT_W-1:0]  db_cnt_d [NUM_IN];
  logic [1:0]        db_prev_q;   // previous debounced step/restart levels
  logic [1:0]        press_q;     // registered rising-edge events: {restart, step}

  assign raw_in = {bus.Restart_Btn, bus.Step_Btn, bus.Run_Sw};

  // Two-flop synchronizer for each asynchronous board input.
  // NOTE: sequential state always uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge Clk_100MHz or posedge Reset) begin
    if (Reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw_in;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: accept a new level after it has differed for DEBOUNCE_CYCLES cycles.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    db_d = db_q;
    for (int i = 0; i < NUM_IN; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != db_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          db_d[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Debounce state and rising-edge press detection for step/restart.
  always_ff @(posedge Clk_100MHz or posedge Reset) begin
    if (Reset) begin
      db_q      <= '0;
      db_prev_q <= '0;
      press_q   <= '0;
      for (int i = 0; i < NUM_IN; i++) begin
        db_cnt_q[i] <= '0;
      end
    end else begin
      db_q      <= db_d;
      db_prev_q <= {db_q[IDX_RESTART], db_q[IDX_STEP]};
      press_q   <= {db_q[IDX_RESTART], db_q[IDX_STEP]} & ~db_prev_q;
      for (int i = 0; i < NUM_IN; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
      end
    end
  end

  logic run_lvl, step_evt, restart_evt;
  assign run_lvl     = db_q[IDX_RUN];
  assign step_evt    = press_q[0];
  assign restart_evt = press_q[1];

  // ------------------------------------------------------------------
  // Sequencer state, prescaler and outputs
  // ------------------------------------------------------------------
  state_e          state_q, state_d;
  logic [PS_W-1:0] prescaler_q, prescaler_d;
  logic            ce_q, ce_d;
  logic            restart_q, restart_d;
  logic [15:0]     count_q, count_d;
  logic            tick;
  logic            brk_hit;
  logic            brk_hold;

  // The prescaler is only nonzero while in RUN, so reaching PS_LAST is a RUN tick.
  assign tick = (state_q == ST_RUN) && (prescaler_q == PS_LAST);

`ifdef STEP_CTRL_BRK_EN
  logic armed_q, armed_d;
  logic hold_q, hold_d;

  assign brk_hit  = tick && bus.Brk_En && armed_q && (bus.PC_In == bus.Brk_Addr);
  assign brk_hold = hold_q;

  // Arm after the first tick in RUN; hold HALT after a hit until Run drops.
  always_comb begin
    armed_d = armed_q;
    hold_d  = hold_q;
    if ((state_q != ST_RUN) && (state_d == ST_RUN)) begin
      armed_d = 1'b0;
    end else if (tick) begin
      armed_d = 1'b1;
    end
    if (!run_lvl || (state_d == ST_RESTART)) begin
      hold_d = 1'b0;
    end else if (brk_hit && (state_d == ST_HALT)) begin
      hold_d = 1'b1;
    end
  end

  // Breakpoint arm/hold registers.
  always_ff @(posedge Clk_100MHz or posedge Reset) begin
    if (Reset) begin
      armed_q <= 1'b0;
      hold_q  <= 1'b0;
    end else begin
      armed_q <= armed_d;
      hold_q  <= hold_d;
    end
  end
`else
  assign brk_hit  = 1'b0;
  assign brk_hold = 1'b0;
`endif

  // State register.
  always_ff @(posedge Clk_100MHz or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_HALT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state; restart outranks run drop, which outranks breakpoint and tick/step.
  always_comb begin
    state_d = state_q;
    if (restart_evt) begin
      state_d = ST_RESTART;
    end else begin
      case (state_q)
        ST_HALT: begin
          if (run_lvl && !brk_hold) begin
            state_d = ST_RUN;
          end else if (step_evt) begin
            state_d = ST_STEP;
          end
        end
        ST_RUN: begin
          if (!run_lvl || brk_hit) begin
            state_d = ST_HALT;
          end
        end
        default: state_d = ST_HALT;   // STEP and RESTART last exactly one cycle
      endcase
    end
  end

  // Output and datapath next values, registered below.
  always_comb begin
    prescaler_d = '0;
    if ((state_q == ST_RUN) && (state_d == ST_RUN)) begin
      prescaler_d = tick ? '0 : prescaler_q + PS_W'(1);
    end
    ce_d      = (state_d == ST_STEP) ||
                ((state_q == ST_RUN) && (state_d == ST_RUN) && tick);
    restart_d = (state_d == ST_RESTART);
    count_d   = count_q;
    if (state_d == ST_RESTART) begin
      count_d = '0;
    end else if (ce_q && (count_q != 16'hFFFF)) begin
      count_d = count_q + 16'd1;
    end
  end

  // Registered outputs, prescaler and instruction counter.
  always_ff @(posedge Clk_100MHz or posedge Reset) begin
    if (Reset) begin
      prescaler_q <= '0;
      ce_q        <= 1'b0;
      restart_q   <= 1'b0;
      count_q     <= '0;
    end else begin
      prescaler_q <= prescaler_d;
      ce_q        <= ce_d;
      restart_q   <= restart_d;
      count_q     <= count_d;
    end
  end

  assign bus.Cpu_Ce      = ce_q;
  assign bus.Cpu_Restart = restart_q;
  assign bus.State       = state_q;
  assign bus.Cycle_Count = count_q;

endmodule

// File: tb/tb_cpu_step_controller.sv
// Directed bench for cpu_step_controller with TICK_DIV=4, DEBOUNCE_CYCLES=3.
// Inputs change on the falling edge; outputs are read on the falling edge,
// so "edge k" below means the k-th rising edge after an input change.
module tb_cpu_step_controller;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  cpu_step_controller_if #(.PC_W(16)) bus ();

  cpu_step_controller #(
    .TICK_DIV(4),
    .DEBOUNCE_CYCLES(3),
    .PC_W(16)
  ) dut (
    .Clk_100MHz(clk),
    .Reset(rst),
    .bus(bus.slave)
  );

  // Reset asserted mid-RUN clears everything at once; nothing runs afterwards.
  task automatic test_reset();
    int ce_seen;
    bus.Run_Sw = 1'b1;
    repeat (12) @(negedge clk);
    total++;
    if (bus.State !== 2'b01) begin
      bad++; $display("FAIL pre_reset_state: got %0d expected %0d", bus.State, 1);
    end
    total++;
    if (bus.Cycle_Count !== 16'd1) begin
      bad++; $display("FAIL pre_reset_count: got %0d expected %0d", bus.Cycle_Count, 1);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if (bus.State !== 2'b00) begin
      bad++; $display("FAIL reset_state: got %0d expected %0d", bus.State, 0);
    end
    total++;
    if (bus.Cpu_Ce !== 1'b0) begin
      bad++; $display("FAIL reset_ce: got %0d expected %0d", bus.Cpu_Ce, 0);
    end
    total++;
    if (bus.Cycle_Count !== 16'd0) begin
      bad++; $display("FAIL reset_count: got %0d expected %0d", bus.Cycle_Count, 0);
    end
    @(negedge clk);
    bus.Run_Sw = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    ce_seen = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus.Cpu_Ce === 1'b1) ce_seen++;
    end
    total++;
    if (ce_seen != 0) begin
      bad++; $display("FAIL post_reset_ce: got %0d pulses expected %0d", ce_seen, 0);
    end
    total++;
    if (bus.State !== 2'b00) begin
      bad++; $display("FAIL post_reset_state: got %0d expected %0d", bus.State, 0);
    end
  endtask

  // Held step button: one pulse at edge 7 (2 sync + 3 debounce + 1 press + 1 FSM).
  task automatic test_step();
    int n, first;
    logic [1:0] st7, st8;
    n = 0; first = 0; st7 = 2'b11; st8 = 2'b11;
    bus.Step_Btn = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      if (bus.Cpu_Ce === 1'b1) begin
        n++;
        if (first == 0) first = k;
      end
      if (k == 7) st7 = bus.State;
      if (k == 8) st8 = bus.State;
      if (k == 10) bus.Step_Btn = 1'b0;
    end
    total++;
    if (n != 1) begin
      bad++; $display("FAIL step_pulses: got %0d expected %0d", n, 1);
    end
    total++;
    if (first != 7) begin
      bad++; $display("FAIL step_latency: got %0d expected %0d", first, 7);
    end
    total++;
    if (st7 !== 2'b10) begin
      bad++; $display("FAIL step_state_in_step: got %0d expected %0d", st7, 2);
    end
    total++;
    if (st8 !== 2'b00) begin
      bad++; $display("FAIL step_state_after: got %0d expected %0d", st8, 0);
    end
    total++;
    if (bus.Cycle_Count !== 16'd1) begin
      bad++; $display("FAIL step_count: got %0d expected %0d", bus.Cycle_Count, 1);
    end
  endtask

  // Step button bouncing every 2 cycles never survives a 3-cycle debounce.
  task automatic test_bounce();
    int n;
    n = 0;
    for (int k = 0; k < 12; k++) begin
      bus.Step_Btn = ((k / 2) % 2 == 0);
      @(negedge clk);
      if (bus.Cpu_Ce === 1'b1) n++;
    end
    bus.Step_Btn = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.Cpu_Ce === 1'b1) n++;
    end
    total++;
    if (n != 0) begin
      bad++; $display("FAIL bounce_pulses: got %0d expected %0d", n, 0);
    end
    total++;
    if (bus.Cycle_Count !== 16'd1) begin
      bad++; $display("FAIL bounce_count: got %0d expected %0d", bus.Cycle_Count, 1);
    end
  endtask

  // Run switch held for 40 cycles: pulses at edges 10,14,...,42.
  task automatic test_run();
    int n, first, last, prev, spacing_bad;
    logic [15:0] base;
    n = 0; first = 0; last = 0; prev = 0; spacing_bad = 0;
    base = bus.Cycle_Count;
    bus.Run_Sw = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (bus.Cpu_Ce === 1'b1) begin
        if (prev != 0 && (k - prev) != 4) spacing_bad++;
        if (first == 0) first = k;
        prev = k; last = k; n++;
      end
      if (k == 40) bus.Run_Sw = 1'b0;
    end
    total++;
    if (n != 9) begin
      bad++; $display("FAIL run_pulses: got %0d expected %0d", n, 9);
    end
    total++;
    if (first != 10) begin
      bad++; $display("FAIL run_first_pulse: got edge %0d expected edge %0d", first, 10);
    end
    total++;
    if (spacing_bad != 0) begin
      bad++; $display("FAIL run_spacing: got %0d bad gaps expected %0d", spacing_bad, 0);
    end
    total++;
    if (last > 46) begin
      bad++; $display("FAIL run_stop: got last edge %0d expected at most %0d", last, 46);
    end
    total++;
    if (bus.Cycle_Count !== base + 16'd9) begin
      bad++; $display("FAIL run_count: got %0d expected %0d", bus.Cycle_Count, base + 16'd9);
    end
    total++;
    if (bus.State !== 2'b00) begin
      bad++; $display("FAIL run_halted: got %0d expected %0d", bus.State, 0);
    end
  endtask

  // Breakpoint at PC 5: five instructions, halt, then resume executes PC 5.
  task automatic test_breakpoint();
    int n, first;
    logic [15:0] pc_at_first;
    n = 0; first = 0; pc_at_first = 16'hDEAD;
    bus.PC_In    = 16'h0000;
    bus.Brk_Addr = 16'h0005;
    bus.Brk_En   = 1'b1;
    bus.Run_Sw   = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (bus.Cpu_Ce === 1'b1) begin
        n++;
        bus.PC_In = bus.PC_In + 16'd1;
      end
    end
`ifdef STEP_CTRL_BRK_EN
    total++;
    if (n != 5) begin
      bad++; $display("FAIL brk_pulses: got %0d expected %0d", n, 5);
    end
    total++;
    if (bus.State !== 2'b00) begin
      bad++; $display("FAIL brk_state: got %0d expected %0d", bus.State, 0);
    end
    total++;
    if (bus.PC_In !== 16'h0005) begin
      bad++; $display("FAIL brk_pc: got %0d expected %0d", bus.PC_In, 5);
    end
    bus.Run_Sw = 1'b0;
    repeat (8) @(negedge clk);
    bus.Run_Sw = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus.Cpu_Ce === 1'b1) begin
        if (first == 0) begin
          first = k;
          pc_at_first = bus.PC_In;
        end
        bus.PC_In = bus.PC_In + 16'd1;
      end
    end
    total++;
    if (first != 10) begin
      bad++; $display("FAIL brk_resume_edge: got %0d expected %0d", first, 10);
    end
    total++;
    if (pc_at_first !== 16'h0005) begin
      bad++; $display("FAIL brk_resume_pc: got %0d expected %0d", pc_at_first, 5);
    end
`else
    total++;
    if (n != 13) begin
      bad++; $display("FAIL nobrk_pulses: got %0d expected %0d", n, 13);
    end
    total++;
    if (bus.State !== 2'b01) begin
      bad++; $display("FAIL nobrk_state: got %0d expected %0d", bus.State, 1);
    end
`endif
    bus.Run_Sw = 1'b0;
    bus.Brk_En = 1'b0;
    repeat (10) @(negedge clk);
    total++;
    if (bus.State !== 2'b00) begin
      bad++; $display("FAIL brk_exit_state: got %0d expected %0d", bus.State, 0);
    end
  endtask

  // Restart press lands at Cycle_Count=7 during RUN: RESTART at edge 37.
  task automatic test_restart();
    int rs_pulses, overlap;
    logic [15:0] c36, c37;
    logic [1:0]  s37, s38, s39;
    logic        ce37, rs37, rs38;
    rs_pulses = 0; overlap = 0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    bus.Run_Sw = 1'b1;
    c36 = 'x; c37 = 'x; s37 = 'x; s38 = 'x; s39 = 'x; ce37 = 'x; rs37 = 'x; rs38 = 'x;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      if (bus.Cpu_Restart === 1'b1) rs_pulses++;
      if (bus.Cpu_Restart === 1'b1 && bus.Cpu_Ce === 1'b1) overlap++;
      if (k == 36) c36 = bus.Cycle_Count;
      if (k == 37) begin
        s37 = bus.State; ce37 = bus.Cpu_Ce; rs37 = bus.Cpu_Restart; c37 = bus.Cycle_Count;
      end
      if (k == 38) begin
        s38 = bus.State; rs38 = bus.Cpu_Restart;
      end
      if (k == 39) s39 = bus.State;
      if (k == 30) bus.Restart_Btn = 1'b1;
      if (k == 40) bus.Restart_Btn = 1'b0;
    end
    total++;
    if (c36 !== 16'd7) begin
      bad++; $display("FAIL rst_count_before: got %0d expected %0d", c36, 7);
    end
    total++;
    if (s37 !== 2'b11) begin
      bad++; $display("FAIL rst_state: got %0d expected %0d", s37, 3);
    end
    total++;
    if (rs37 !== 1'b1) begin
      bad++; $display("FAIL rst_pulse: got %0d expected %0d", rs37, 1);
    end
    total++;
    if (ce37 !== 1'b0) begin
      bad++; $display("FAIL rst_ce: got %0d expected %0d", ce37, 0);
    end
    total++;
    if (c37 !== 16'd0) begin
      bad++; $display("FAIL rst_count: got %0d expected %0d", c37, 0);
    end
    total++;
    if (s38 !== 2'b00 || rs38 !== 1'b0) begin
      bad++; $display("FAIL rst_to_halt: got state %0d pulse %0d expected state 0 pulse 0", s38, rs38);
    end
    total++;
    if (s39 !== 2'b01) begin
      bad++; $display("FAIL rst_rerun: got %0d expected %0d", s39, 1);
    end
    total++;
    if (rs_pulses != 1 || overlap != 0) begin
      bad++; $display("FAIL rst_single: got %0d pulses %0d overlaps expected 1 and 0", rs_pulses, overlap);
    end
    bus.Run_Sw = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    rst             = 1'b1;
    bus.Run_Sw      = 1'b0;
    bus.Step_Btn    = 1'b0;
    bus.Restart_Btn = 1'b0;
    bus.PC_In       = 16'h0000;
    bus.Brk_Addr    = 16'h0000;
    bus.Brk_En      = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_step();
    test_bounce();
    test_run();
    test_breakpoint();
    test_restart();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
